idu_pipe: RTL and testbench

- Pipelined, parametrised RV32 instruction decode stage. Successor to the combinational RV32I decoder.
- Adds valid/ready handshaking, a registered output stage, flush, and optional RV32M decoding.
- Adds immediate generation, register-field extraction, illegal-instruction detection and a decoded-instruction counter.
- Sits between the fetch unit (IFU) and the execute unit (EXU).

---
 rtl/idu_pipe.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// RV32I(+M) decode stage between fetch and execute: one-deep registered output
// with valid/ready handshaking, flush, immediate generation and a handshake counter.
module idu_pipe #(
    parameter bit EN_M  = 1'b1,
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_op,
    output logic             out_illegal,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic             out_we,
    output logic [31:0]      out_imm,
    output logic [31:0]      out_pc,
    output logic [CNT_W-1:0] dec_cnt
);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [31:0] WORD_ECALL  = 32'h0000_0073;
    localparam logic [31:0] WORD_EBREAK = 32'h0010_0073;

    localparam logic [5:0] OP_ADD    = 6'd0;
    localparam logic [5:0] OP_SUB    = 6'd1;
    localparam logic [5:0] OP_XOR    = 6'd2;
    localparam logic [5:0] OP_OR     = 6'd3;
    localparam logic [5:0] OP_AND    = 6'd4;
    localparam logic [5:0] OP_SLL    = 6'd5;
    localparam logic [5:0] OP_SRL    = 6'd6;
    localparam logic [5:0] OP_SRA    = 6'd7;
    localparam logic [5:0] OP_SLT    = 6'd8;
    localparam logic [5:0] OP_SLTU   = 6'd9;
    localparam logic [5:0] OP_ADDI   = 6'd10;
    localparam logic [5:0] OP_XORI   = 6'd11;
    localparam logic [5:0] OP_ORI    = 6'd12;
    localparam logic [5:0] OP_ANDI   = 6'd13;
    localparam logic [5:0] OP_SLLI   = 6'd14;
    localparam logic [5:0] OP_SRLI   = 6'd15;
    localparam logic [5:0] OP_SRAI   = 6'd16;
    localparam logic [5:0] OP_SLTI   = 6'd17;
    localparam logic [5:0] OP_SLTIU  = 6'd18;
    localparam logic [5:0] OP_LB     = 6'd19;
    localparam logic [5:0] OP_LH     = 6'd20;
    localparam logic [5:0] OP_LW     = 6'd21;
    localparam logic [5:0] OP_LBU    = 6'd22;
    localparam logic [5:0] OP_LHU    = 6'd23;
    localparam logic [5:0] OP_SB     = 6'd24;
    localparam logic [5:0] OP_SH     = 6'd25;
    localparam logic [5:0] OP_SW     = 6'd26;
    localparam logic [5:0] OP_BEQ    = 6'd27;
    localparam logic [5:0] OP_BNE    = 6'd28;
    localparam logic [5:0] OP_BLT    = 6'd29;
    localparam logic [5:0] OP_BGE    = 6'd30;
    localparam logic [5:0] OP_BLTU   = 6'd31;
    localparam logic [5:0] OP_BGEU   = 6'd32;
    localparam logic [5:0] OP_JAL    = 6'd33;
    localparam logic [5:0] OP_JALR   = 6'd34;
    localparam logic [5:0] OP_LUI    = 6'd35;
    localparam logic [5:0] OP_AUIPC  = 6'd36;
    localparam logic [5:0] OP_ECALL  = 6'd37;
    localparam logic [5:0] OP_EBREAK = 6'd38;
    localparam logic [5:0] OP_MUL    = 6'd39;

    localparam logic [OP_W-1:0] OP_ILLEGAL = '1;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_SH
    } imm_kind_e;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign rd_f   = in_inst[11:7];
    assign rs1_f  = in_inst[19:15];
    assign rs2_f  = in_inst[24:20];

    logic       dec_ok;
    logic [5:0] dec_idx;
    logic       dec_wr;
    imm_kind_e  dec_kind;

    // Opcode/funct decode; anything not matched leaves dec_ok low, which also
    // catches inst[1:0] != 2'b11 since every listed opcode ends in 2'b11.
    always_comb begin
        dec_ok   = 1'b0;
        dec_idx  = '0;
        dec_wr   = 1'b0;
        dec_kind = IMM_NONE;
        case (opcode)
            OPC_OP: begin
                dec_wr = 1'b1;
                if (funct7 == 7'h00) begin
                    dec_ok = 1'b1;
                    case (funct3)
                        3'd0:    dec_idx = OP_ADD;
                        3'd1:    dec_idx = OP_SLL;
                        3'd2:    dec_idx = OP_SLT;
                        3'd3:    dec_idx = OP_SLTU;
                        3'd4:    dec_idx = OP_XOR;
                        3'd5:    dec_idx = OP_SRL;
                        3'd6:    dec_idx = OP_OR;
                        default: dec_idx = OP_AND;
                    endcase
                end else if (funct7 == 7'h20) begin
                    if (funct3 == 3'd0) begin
                        dec_ok  = 1'b1;
                        dec_idx = OP_SUB;
                    end else if (funct3 == 3'd5) begin
                        dec_ok  = 1'b1;
                        dec_idx = OP_SRA;
                    end
                end else if (funct7 == 7'h01 && EN_M) begin
                    dec_ok  = 1'b1;
                    dec_idx = OP_MUL + {3'b000, funct3};
                end
            end
            OPC_IMM: begin
                dec_wr   = 1'b1;
                dec_kind = IMM_I;
                dec_ok   = 1'b1;
                case (funct3)
                    3'd0: dec_idx = OP_ADDI;
                    3'd2: dec_idx = OP_SLTI;
                    3'd3: dec_idx = OP_SLTIU;
                    3'd4: dec_idx = OP_XORI;
                    3'd6: dec_idx = OP_ORI;
                    3'd7: dec_idx = OP_ANDI;
                    3'd1: begin
                        dec_kind = IMM_SH;
                        dec_idx  = OP_SLLI;
                        dec_ok   = (funct7 == 7'h00);
                    end
                    default: begin
                        dec_kind = IMM_SH;
                        dec_idx  = (funct7 == 7'h20) ? OP_SRAI : OP_SRLI;
                        dec_ok   = (funct7 == 7'h00) || (funct7 == 7'h20);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_wr   = 1'b1;
                dec_kind = IMM_I;
                dec_ok   = 1'b1;
                case (funct3)
                    3'd0:    dec_idx = OP_LB;
                    3'd1:    dec_idx = OP_LH;
                    3'd2:    dec_idx = OP_LW;
                    3'd4:    dec_idx = OP_LBU;
                    3'd5:    dec_idx = OP_LHU;
                    default: dec_ok  = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec_kind = IMM_S;
                dec_ok   = (funct3 <= 3'd2);
                case (funct3)
                    3'd0:    dec_idx = OP_SB;
                    3'd1:    dec_idx = OP_SH;
                    default: dec_idx = OP_SW;
                endcase
            end
            OPC_BRANCH: begin
                dec_kind = IMM_B;
                dec_ok   = 1'b1;
                case (funct3)
                    3'd0:    dec_idx = OP_BEQ;
                    3'd1:    dec_idx = OP_BNE;
                    3'd4:    dec_idx = OP_BLT;
                    3'd5:    dec_idx = OP_BGE;
                    3'd6:    dec_idx = OP_BLTU;
                    3'd7:    dec_idx = OP_BGEU;
                    default: dec_ok  = 1'b0;
                endcase
            end
            OPC_JAL: begin
                dec_ok   = 1'b1;
                dec_wr   = 1'b1;
                dec_kind = IMM_J;
                dec_idx  = OP_JAL;
            end
            OPC_JALR: begin
                dec_ok   = (funct3 == 3'd0);
                dec_wr   = 1'b1;
                dec_kind = IMM_I;
                dec_idx  = OP_JALR;
            end
            OPC_LUI: begin
                dec_ok   = 1'b1;
                dec_wr   = 1'b1;
                dec_kind = IMM_U;
                dec_idx  = OP_LUI;
            end
            OPC_AUIPC: begin
                dec_ok   = 1'b1;
                dec_wr   = 1'b1;
                dec_kind = IMM_U;
                dec_idx  = OP_AUIPC;
            end
            OPC_SYSTEM: begin
                if (in_inst == WORD_ECALL) begin
                    dec_ok  = 1'b1;
                    dec_idx = OP_ECALL;
                end else if (in_inst == WORD_EBREAK) begin
                    dec_ok  = 1'b1;
                    dec_idx = OP_EBREAK;
                end
            end
            default: dec_ok = 1'b0;
        endcase
    end

    logic [31:0] imm_val;

    always_comb begin
        imm_val = '0;
        case (dec_kind)
            IMM_I:   imm_val = {{20{in_inst[31]}}, in_inst[31:20]};
            IMM_S:   imm_val = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            IMM_B:   imm_val = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                in_inst[30:25], in_inst[11:8], 1'b0};
            IMM_U:   imm_val = {in_inst[31:12], 12'b0};
            IMM_J:   imm_val = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                in_inst[20], in_inst[30:21], 1'b0};
            IMM_SH:  imm_val = {27'b0, in_inst[24:20]};
            default: imm_val = '0;
        endcase
    end

    logic [OP_W-1:0] dec_op;
    logic [31:0]     dec_imm;
    logic            dec_we;

    assign dec_op  = dec_ok ? OP_W'(dec_idx) : OP_ILLEGAL;
    assign dec_imm = dec_ok ? imm_val : 32'b0;
    assign dec_we  = dec_ok && dec_wr && (rd_f != 5'd0);

    // Handshake: a word moves on a rising edge where valid && ready are both
    // high; valid never waits on ready, and a held output stays frozen while
    // out_ready is low. in_ready admits a new word in the same cycle the held
    // one drains, so the stage streams one word per cycle.
    logic accept;
    logic drain;

    assign in_ready = !rst && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_illegal <= 1'b0;
            out_rd      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_we      <= 1'b0;
            out_imm     <= '0;
            out_pc      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= dec_op;
            out_illegal <= !dec_ok;
            out_rd      <= rd_f;
            out_rs1     <= rs1_f;
            out_rs2     <= rs2_f;
            out_we      <= dec_we;
            out_imm     <= dec_imm;
            out_pc      <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Counts consumed words, including the one leaving during a flush cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_cnt <= '0;
        end else if (drain) begin
            dec_cnt <= dec_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe: two instances (RV32M on / off with a 4-bit counter) fed the
// same stream, checked every cycle against a table-driven decode reference.
module tb_idu_pipe;

    localparam int OP_W = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;

    logic            in_ready_a, out_valid_a, out_illegal_a, out_we_a;
    logic [OP_W-1:0] out_op_a;
    logic [4:0]      out_rd_a, out_rs1_a, out_rs2_a;
    logic [31:0]     out_imm_a, out_pc_a, dec_cnt_a;

    logic            in_ready_b, out_valid_b, out_illegal_b, out_we_b;
    logic [OP_W-1:0] out_op_b;
    logic [4:0]      out_rd_b, out_rs1_b, out_rs2_b;
    logic [31:0]     out_imm_b, out_pc_b;
    logic [3:0]      dec_cnt_b;

    idu_pipe #(.EN_M(1'b1), .OP_W(OP_W), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_op(out_op_a), .out_illegal(out_illegal_a), .out_rd(out_rd_a), .out_rs1(out_rs1_a),
        .out_rs2(out_rs2_a), .out_we(out_we_a), .out_imm(out_imm_a), .out_pc(out_pc_a),
        .dec_cnt(dec_cnt_a)
    );

    idu_pipe #(.EN_M(1'b0), .OP_W(OP_W), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_op(out_op_b), .out_illegal(out_illegal_b), .out_rd(out_rd_b), .out_rs1(out_rs1_b),
        .out_rs2(out_rs2_b), .out_we(out_we_b), .out_imm(out_imm_b), .out_pc(out_pc_b),
        .dec_cnt(dec_cnt_b)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: per-op match pattern (opcode, funct3 or -1, funct7 or -1).
    int pat_opc [47] = '{'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33,
                         'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13, 'h13,
                         'h03, 'h03, 'h03, 'h03, 'h03,
                         'h23, 'h23, 'h23,
                         'h63, 'h63, 'h63, 'h63, 'h63, 'h63,
                         'h6F, 'h67, 'h37, 'h17, 'h73, 'h73,
                         'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33, 'h33};
    int pat_f3 [47] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3,
                        0, 4, 6, 7, 1, 5, 5, 2, 3,
                        0, 1, 2, 4, 5,
                        0, 1, 2,
                        0, 1, 4, 5, 6, 7,
                        -1, 0, -1, -1, -1, -1,
                        0, 1, 2, 3, 4, 5, 6, 7};
    int pat_f7 [47] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0,
                        -1, -1, -1, -1, 0, 0, 32, -1, -1,
                        -1, -1, -1, -1, -1,
                        -1, -1, -1,
                        -1, -1, -1, -1, -1, -1,
                        -1, -1, -1, -1, -1, -1,
                        1, 1, 1, 1, 1, 1, 1, 1};

    typedef struct packed {
        logic [5:0]  op;
        logic        illegal;
        logic        we;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t ref_decode(input logic [31:0] w, input bit en_m);
        dec_t r;
        int op;
        op = -1;
        if (w == 32'h0000_0073) op = 37;
        else if (w == 32'h0010_0073) op = 38;
        else begin
            for (int k = 0; k < 47; k++) begin
                if (k == 37 || k == 38) continue;
                if (int'(w[6:0]) == pat_opc[k] &&
                    (pat_f3[k] < 0 || int'(w[14:12]) == pat_f3[k]) &&
                    (pat_f7[k] < 0 || int'(w[31:25]) == pat_f7[k]))
                    op = k;
            end
        end
        if (op >= 39 && !en_m) op = -1;
        if (op < 0) begin
            r.op = 6'h3F; r.illegal = 1'b1; r.we = 1'b0; r.imm = '0;
            return r;
        end
        r.op = 6'(op);
        r.illegal = 1'b0;
        if (op >= 14 && op <= 16)                      r.imm = {27'b0, w[24:20]};
        else if ((op >= 10 && op <= 23) || op == 34)   r.imm = {{20{w[31]}}, w[31:20]};
        else if (op >= 24 && op <= 26)                 r.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        else if (op >= 27 && op <= 32)
            r.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        else if (op == 33)
            r.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        else if (op == 35 || op == 36)                 r.imm = {w[31:12], 12'b0};
        else                                           r.imm = '0;
        r.we = (op <= 23 || (op >= 33 && op <= 36) || op >= 39) && (w[11:7] != 5'd0);
        return r;
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        int mode, k;
        mode = $urandom_range(0, 9);
        w = $urandom;
        if (mode == 7) return w;
        k = $urandom_range(0, 46);
        if (k == 37) return 32'h0000_0073;
        if (k == 38) return 32'h0010_0073;
        w[6:0] = 7'(pat_opc[k]);
        if (pat_f3[k] >= 0) w[14:12] = 3'(pat_f3[k]);
        if (pat_f7[k] >= 0) w[31:25] = 7'(pat_f7[k]);
        if (mode >= 8) w[$urandom_range(0, 31)] ^= 1'b1;
        return w;
    endfunction

    // scoreboard: held word as {pc, inst}
    logic [63:0] exp_q[$];
    logic [63:0] last_rec = '0;
    bit          last_zero = 1'b1;
    logic [31:0] m_cnt_a = '0;
    logic [3:0]  m_cnt_b = '0;
    bit          m_ready;
    bit          hs;

    always @(negedge clk) begin
        logic [63:0] cur;
        bit          cur_zero;
        dec_t        e_a, e_b;
        logic [4:0]  e_rd, e_rs1, e_rs2;
        logic [31:0] e_pc;

        m_ready = !rst && !flush && (exp_q.size() == 0 || out_ready);
        check_val("in_ready_a", 64'(in_ready_a), 64'(m_ready));
        check_val("in_ready_b", 64'(in_ready_b), 64'(m_ready));
        check_val("out_valid_a", 64'(out_valid_a), 64'(exp_q.size() != 0));
        check_val("out_valid_b", 64'(out_valid_b), 64'(exp_q.size() != 0));

        if (exp_q.size() != 0) begin
            cur = exp_q[0]; cur_zero = 1'b0;
        end else begin
            cur = last_rec; cur_zero = last_zero;
        end
        if (cur_zero) begin
            e_a = '0; e_b = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_pc = '0;
        end else begin
            e_a = ref_decode(cur[31:0], 1'b1);
            e_b = ref_decode(cur[31:0], 1'b0);
            e_rd = cur[11:7]; e_rs1 = cur[19:15]; e_rs2 = cur[24:20]; e_pc = cur[63:32];
        end
        check_val("op_a", 64'(out_op_a), 64'(e_a.op));
        check_val("illegal_a", 64'(out_illegal_a), 64'(e_a.illegal));
        check_val("we_a", 64'(out_we_a), 64'(e_a.we));
        check_val("imm_a", 64'(out_imm_a), 64'(e_a.imm));
        check_val("op_b", 64'(out_op_b), 64'(e_b.op));
        check_val("illegal_b", 64'(out_illegal_b), 64'(e_b.illegal));
        check_val("we_b", 64'(out_we_b), 64'(e_b.we));
        check_val("imm_b", 64'(out_imm_b), 64'(e_b.imm));
        check_val("regs_a", 64'({out_rd_a, out_rs1_a, out_rs2_a}), 64'({e_rd, e_rs1, e_rs2}));
        check_val("regs_b", 64'({out_rd_b, out_rs1_b, out_rs2_b}), 64'({e_rd, e_rs1, e_rs2}));
        check_val("pc_a", 64'(out_pc_a), 64'(e_pc));
        check_val("pc_b", 64'(out_pc_b), 64'(e_pc));
        check_val("cnt_a", 64'(dec_cnt_a), 64'(m_cnt_a));
        check_val("cnt_b", 64'(dec_cnt_b), 64'(m_cnt_b));

        // advance the model across the coming edge
        if (rst) begin
            exp_q.delete();
            last_zero = 1'b1;
            last_rec = '0;
            m_cnt_a = '0;
            m_cnt_b = '0;
        end else begin
            hs = (exp_q.size() != 0) && out_ready;
            if (hs) begin
                m_cnt_a = m_cnt_a + 32'd1;
                m_cnt_b = m_cnt_b + 4'd1;
            end
            if ((hs || flush) && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && m_ready) begin
                exp_q.push_back({in_pc, in_inst});
                last_rec = {in_pc, in_inst};
                last_zero = 1'b0;
            end
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic dir_check(input string tag, input logic [31:0] w, input int op_a, input int op_b,
                             input logic [31:0] imm, input bit we, input int rd, input int rs1,
                             input int rs2);
        in_valid = 1'b1; in_inst = w; in_pc = $urandom; out_ready = 1'b1; flush = 1'b0;
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_valid"}, 64'(out_valid_a), 64'd1);
        check_val({tag, "_op"}, 64'(out_op_a), 64'(op_a));
        check_val({tag, "_op_nom"}, 64'(out_op_b), 64'(op_b));
        check_val({tag, "_illegal"}, 64'(out_illegal_a), 64'(op_a == 63));
        check_val({tag, "_illegal_nom"}, 64'(out_illegal_b), 64'(op_b == 63));
        check_val({tag, "_imm"}, 64'(out_imm_a), 64'(imm));
        check_val({tag, "_we"}, 64'(out_we_a), 64'(we));
        check_val({tag, "_rd"}, 64'(out_rd_a), 64'(rd));
        check_val({tag, "_rs"}, 64'({out_rs1_a, out_rs2_a}), 64'({5'(rs1), 5'(rs2)}));
        next_cycle();
    endtask

    task automatic drive_rand(input bit v, input bit ordy, input bit fl, input bit r);
        in_valid = v; out_ready = ordy; flush = fl; rst = r;
        in_inst = gen_word(); in_pc = $urandom;
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_inst = 32'h0020_81B3; in_pc = '0;

        // reset held two cycles with a word offered
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready_a), 64'd0);
        check_val("rst_out_valid", 64'(out_valid_a), 64'd0);
        check_val("rst_cnt", 64'(dec_cnt_a), 64'd0);
        next_cycle();
        rst = 1'b0;

        dir_check("add",  32'h0020_81B3, 0, 0, 32'h0, 1'b1, 3, 1, 2);
        dir_check("addi", 32'hFFF0_0093, 10, 10, 32'hFFFF_FFFF, 1'b1, 1, 0, 31);
        dir_check("sw",   32'h0020_A423, 26, 26, 32'h8, 1'b0, 8, 1, 2);
        dir_check("jal",  32'hFFDF_F0EF, 33, 33, 32'hFFFF_FFFC, 1'b1, 1, 31, 29);
        dir_check("mul",  32'h0273_02B3, 39, 63, 32'h0, 1'b1, 5, 6, 7);
        dir_check("zero", 32'h0000_0000, 63, 63, 32'h0, 1'b0, 0, 0, 0);

        // backpressure: load one word, stall three cycles, then stream
        in_valid = 1'b1; in_inst = gen_word(); in_pc = $urandom; out_ready = 1'b1;
        next_cycle();
        in_inst = gen_word(); in_pc = $urandom; out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_val("bp_in_ready", 64'(in_ready_a), 64'd0);
            check_val("bp_out_valid", 64'(out_valid_a), 64'd1);
            next_cycle();
        end
        out_ready = 1'b1;
        repeat (4) begin
            in_inst = gen_word(); in_pc = $urandom;
            next_cycle();
        end
        in_valid = 1'b0;
        next_cycle();

        // flush with a held word and a word offered
        in_valid = 1'b1; in_inst = gen_word(); in_pc = $urandom; out_ready = 1'b0;
        next_cycle();
        flush = 1'b1; in_inst = gen_word(); in_pc = $urandom;
        next_cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_out_valid", 64'(out_valid_a), 64'd0);
        next_cycle();

        // counter wrap: 17 handshakes from reset
        rst = 1'b1; out_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_inst = gen_word(); in_pc = $urandom;
            next_cycle();
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_val("wrap_cnt4", 64'(dec_cnt_b), 64'd1);
        check_val("wrap_cnt32", 64'(dec_cnt_a), 64'd17);
        next_cycle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            drive_rand($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        drive_rand(1'b0, 1'b1, 1'b0, 1'b0);
        drive_rand(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
